// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word bit map and datapath width for the CPU register slice.
// Each datapath register decodes only its own bits of the 32-bit microinstruction.
package cpu_ctrl_pkg;

  localparam int DATA_W      = 16;

  localparam int OFR_LD_BIT  = 12;
  localparam int IFR_RD_BIT  = 13;
  localparam int IFR_CLR_BIT = 14;

endpackage

// File: rtl/ifr_fifo_mem.sv
// DEPTH x DATA_W register array for the input FIFO.
// Writes happen on the clock edge. Reads are combinational from the address.
module ifr_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: The array is intentionally not reset. The count and pointers decide
  // which entries are valid, and leaving out the reset allows the array to map to plain flops or LUT RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ifr_input_port.sv
// Input FIFO plus held operand buffer (BUFF_IFR). A producer pushes words, and the microprogram pops them.
// Optional macro IFR_BYPASS_EN: on an empty FIFO, a push and a pop in the same cycle pass in_data straight into BUFF_IFR.
module ifr_input_port #(
  parameter int DATA_W  = cpu_ctrl_pkg::DATA_W,
  parameter int DEPTH   = 4,
  parameter int RD_BIT  = cpu_ctrl_pkg::IFR_RD_BIT,
  parameter int CLR_BIT = cpu_ctrl_pkg::IFR_CLR_BIT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                control_signal,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          BUFF_IFR,
  output logic                       ifr_empty,
  output logic                       ifr_full,
  output logic [$clog2(DEPTH):0]     ifr_count,
  output logic                       ifr_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_buff;
  logic              r_underflow;

  logic              w_pop_req;
  logic              w_clr;
  logic              w_push;
  logic              w_pop;
  logic              w_bypass;
  logic              w_wr_en;
  logic              w_uf_set;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_unused_ctrl;

  assign w_pop_req     = control_signal[RD_BIT];
  assign w_clr         = control_signal[CLR_BIT];
  // This block reads only two bits of the shared control word. The remaining bits belong to other registers.
  assign w_unused_ctrl = ^control_signal;

  assign ifr_empty = (r_count == '0);
  assign ifr_full  = (r_count == CNT_W'(DEPTH));
  assign in_ready  = !ifr_full;

  assign w_push = in_valid && in_ready;
  assign w_pop  = w_pop_req && !ifr_empty;

`ifdef IFR_BYPASS_EN
  assign w_bypass = w_pop_req && ifr_empty && in_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word goes only to the buffer. It never takes a FIFO slot and never counts as an underflow.
  assign w_wr_en  = w_push && !w_bypass;
  assign w_uf_set = w_pop_req && ifr_empty && !w_bypass;

  ifr_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // NOTE: All state uses non-blocking assignments. Every register therefore samples the values from before the edge,
  // so the order of statements inside this block has no effect on the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_buff      <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_buff   <= w_rd_data;
      end else if (w_bypass) begin
        r_buff   <= in_data;
      end

      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // If a new underflow and a clear arrive in the same cycle, the set takes priority.
      if (w_uf_set) begin
        r_underflow <= 1'b1;
      end else if (w_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign BUFF_IFR      = r_buff;
  assign ifr_count     = r_count;
  assign ifr_underflow = r_underflow;

endmodule

// File: tb/tb_ifr_input_port.sv
// Scoreboard bench for ifr_input_port. Each stimulus step queues the expected state.
// A monitor then compares that state on the falling edge after the step's rising edge.
module tb_ifr_input_port;

  localparam int RD  = 13;
  localparam int CLR = 14;

  typedef struct {
    int          cycle;
    string       name;
    logic [15:0] buff;
    int          count;
    logic        uf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] control_signal;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] BUFF_IFR;
  logic        ifr_empty;
  logic        ifr_full;
  logic [2:0]  ifr_count;
  logic        ifr_underflow;

  exp_t sb[$];
  event mon_ev;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  ifr_input_port dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .control_signal (control_signal),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .BUFF_IFR       (BUFF_IFR),
    .ifr_empty      (ifr_empty),
    .ifr_full       (ifr_full),
    .ifr_count      (ifr_count),
    .ifr_underflow  (ifr_underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops every expectation whose cycle has arrived.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      while (sb.size() > 0 && sb[0].cycle <= cyc) begin
        e = sb.pop_front();
        check({e.name, ".buff"},  BUFF_IFR,      e.buff);
        check({e.name, ".count"}, ifr_count,     e.count);
        check({e.name, ".empty"}, ifr_empty,     e.count == 0);
        check({e.name, ".full"},  ifr_full,      e.count == 4);
        check({e.name, ".ready"}, in_ready,      e.count != 4);
        check({e.name, ".uf"},    ifr_underflow, e.uf);
      end
    end
  end

  task automatic push_exp(input int cy, input string nm, input logic [15:0] b,
                          input int c, input logic u);
    exp_t e;
    e.cycle = cy;
    e.name  = nm;
    e.buff  = b;
    e.count = c;
    e.uf    = u;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs and queue the state expected after the next rising edge.
  task automatic step(input logic v, input logic [15:0] d, input logic rd, input logic clr,
                      input logic [15:0] eb, input int ec, input logic eu, input string nm);
    @(negedge clk);
    in_valid            = v;
    in_data             = d;
    control_signal      = '0;
    control_signal[RD]  = rd;
    control_signal[CLR] = clr;
    push_exp(cyc + 1, nm, eb, ec, eu);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    control_signal = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(0, 16'h0000, 0, 0, 16'h0000, 0, 0, "reset_idle");

    step(1, 16'h1234, 0, 0, 16'h0000, 1, 0, "push_1234");
    step(1, 16'hABCD, 0, 0, 16'h0000, 2, 0, "push_abcd");
    step(0, 16'h0000, 0, 0, 16'h0000, 2, 0, "idle2");
    step(0, 16'h0000, 1, 0, 16'h1234, 1, 0, "pop_1234");
    step(0, 16'h0000, 0, 0, 16'h1234, 1, 0, "hold_1234");
    step(0, 16'h0000, 1, 0, 16'hABCD, 0, 0, "pop_abcd");

    step(1, 16'h0001, 0, 0, 16'hABCD, 1, 0, "fill1");
    step(1, 16'h0002, 0, 0, 16'hABCD, 2, 0, "fill2");
    step(1, 16'h0003, 0, 0, 16'hABCD, 3, 0, "fill3");
    step(1, 16'h0004, 0, 0, 16'hABCD, 4, 0, "fill4_full");
    step(1, 16'h0005, 0, 0, 16'hABCD, 4, 0, "full_ignore5");
    step(1, 16'h0005, 1, 0, 16'h0001, 3, 0, "full_pop_nowrite");
    step(1, 16'h0005, 0, 0, 16'h0001, 4, 0, "accept5");
    step(0, 16'h0000, 1, 0, 16'h0002, 3, 0, "pop2");
    step(0, 16'h0000, 1, 0, 16'h0003, 2, 0, "pop3");
    step(1, 16'h0006, 1, 0, 16'h0004, 2, 0, "pushpop_cnt2");
    step(0, 16'h0000, 1, 0, 16'h0005, 1, 0, "pop5_wrap");
    step(0, 16'h0000, 1, 0, 16'h0006, 0, 0, "pop6");

    step(0, 16'h0000, 1, 0, 16'h0006, 0, 1, "underflow");
    step(0, 16'h0000, 0, 0, 16'h0006, 0, 1, "uf_sticky");
    step(0, 16'h0000, 0, 1, 16'h0006, 0, 0, "uf_clear");
    step(0, 16'h0000, 1, 1, 16'h0006, 0, 1, "uf_set_wins");
    step(0, 16'h0000, 0, 1, 16'h0006, 0, 0, "uf_clear2");

`ifdef IFR_BYPASS_EN
    step(1, 16'h5A5A, 1, 0, 16'h5A5A, 0, 0, "bypass");
    step(0, 16'h0000, 0, 0, 16'h5A5A, 0, 0, "bypass_hold");
`else
    step(1, 16'h5A5A, 1, 0, 16'h0006, 1, 1, "nobypass_push_uf");
    step(0, 16'h0000, 1, 1, 16'h5A5A, 0, 0, "nobypass_pop_clr");
`endif

    step(1, 16'h0007, 0, 0, 16'h5A5A, 1, 0, "pre_rst7");
    step(1, 16'h0008, 0, 0, 16'h5A5A, 2, 0, "pre_rst8");
    step(1, 16'h0009, 0, 0, 16'h5A5A, 3, 0, "pre_rst9");
    step(0, 16'h0000, 0, 0, 16'h5A5A, 3, 0, "pre_rst_idle");
    drain();

    // Assert reset between edges. Outputs must clear before any further rising edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(cyc, "async_reset", 16'h0000, 0, 0);
    ->mon_ev;
    #1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(0, 16'h0000, 0, 0, 16'h0000, 0, 0, "post_rst_idle");
    step(1, 16'h0BEE, 0, 0, 16'h0000, 1, 0, "post_rst_push");
    step(0, 16'h0000, 1, 0, 16'h0BEE, 0, 0, "post_rst_pop");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
